// File: rtl/a51_session_ctrl.sv
// a51_session_ctrl: sequences the A5/1 core through clear/load/warm-up and XORs packed keystream bytes onto a pixel stream
module a51_session_ctrl #(
  parameter int KEY_BITS = 64,
  parameter int FRAME_BITS = 22,
  parameter int WARMUP_STEPS = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [KEY_BITS-1:0]   secret_key,
  input  logic [FRAME_BITS-1:0] public_key,
  output logic                  busy,
  output logic                  key_ready,
  output logic                  core_clear,
  output logic                  core_load,
  output logic                  core_shift_bit,
  output logic                  core_step,
  input  logic                  core_ks,
  input  logic                  pix_in_valid,
  output logic                  pix_in_ready,
  input  logic [7:0]            pix_in_data,
  output logic                  pix_out_valid,
  input  logic                  pix_out_ready,
  output logic [7:0]            pix_out_data
);
  localparam int LW = $clog2(KEY_BITS);
  localparam int FW = $clog2(FRAME_BITS);
  localparam int SW = $clog2(WARMUP_STEPS);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_KEY, LOAD_FRAME, WARMUP, STREAM} state_t;
  state_t state, state_n;
  logic [LW-1:0] ld_cnt, ld_n;
  logic [SW-1:0] st_cnt, st_n;
  logic [2:0] k;
  logic [7:0] ks_byte;
  logic [KEY_BITS-1:0] key_sh;
  logic [FRAME_BITS-1:0] frame_sh;
  logic ks_full, ks_full_n, fill, accept, pov_n;
  assign pix_in_ready = ks_full & (!pix_out_valid | pix_out_ready) & !stop & !reset;
  assign accept = pix_in_valid & pix_in_ready;
  assign fill = core_step & (state == STREAM);
  always_comb begin
    state_n = stop ? IDLE :
              state == IDLE ? (start ? CLEAR : IDLE) :
              state == CLEAR ? LOAD_KEY :
              state == LOAD_KEY ? (ld_cnt == LW'(KEY_BITS - 1) ? LOAD_FRAME : LOAD_KEY) :
              state == LOAD_FRAME ? (ld_cnt == LW'(FRAME_BITS - 1) ? WARMUP : LOAD_FRAME) :
              state == WARMUP ? (st_cnt == SW'(WARMUP_STEPS - 1) ? STREAM : WARMUP) : STREAM;
    ld_n = (state_n == state && (state == LOAD_KEY || state == LOAD_FRAME)) ? ld_cnt + LW'(1) : '0;
    st_n = (state_n == WARMUP && state == WARMUP) ? st_cnt + SW'(1) : '0;
    ks_full_n = state_n != STREAM ? 1'b0 : accept ? 1'b0 : (fill && k == 3'd7) ? 1'b1 : ks_full;
    pov_n = stop ? 1'b0 : accept ? 1'b1 : pix_out_ready ? 1'b0 : pix_out_valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ld_cnt <= '0;
      st_cnt <= '0;
      k <= 3'd0;
      ks_full <= 1'b0;
      pix_out_valid <= 1'b0;
      pix_out_data <= 8'd0;
      busy <= 1'b0;
      key_ready <= 1'b0;
      core_clear <= 1'b1;
      core_load <= 1'b0;
      core_shift_bit <= 1'b0;
      core_step <= 1'b0;
    end else begin
      state <= state_n;
      ld_cnt <= ld_n;
      st_cnt <= st_n;
      ks_full <= ks_full_n;
      k <= stop ? 3'd0 : fill ? k + 3'd1 : k;
      if (fill) ks_byte[k] <= core_ks;
      if (state == IDLE && start && !stop) begin
        key_sh <= secret_key;
        frame_sh <= public_key;
      end
      pix_out_valid <= pov_n;
      if (accept) pix_out_data <= pix_in_data ^ ks_byte;
      busy <= state_n != IDLE;
      key_ready <= state_n == STREAM;
      core_clear <= state_n == CLEAR;
      core_load <= state_n == LOAD_KEY || state_n == LOAD_FRAME;
      core_shift_bit <= state_n == LOAD_KEY ? key_sh[ld_n] :
                        state_n == LOAD_FRAME ? frame_sh[ld_n[FW-1:0]] : 1'b0;
      core_step <= state_n == WARMUP || (state_n == STREAM && !ks_full_n);
    end
  end
endmodule
